mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end between the CPU's memory stage and the word-only data memory (10-bit word address, combinational read when load is high, write on the clock edge when store is high).
- Converts byte, halfword and word requests into data-memory cycles.
- Sub-word stores use a read-modify-write sequence.
- Loads are lane-selected and sign- or zero-extended; misaligned requests are rejected without touching memory.

Parameters:
- ADDR_W, 10, word-address width driven to the data memory.
- RESET_RDATA, 32'h0000_0000, reset value of rdata.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned or illegal request; qualified by resp_valid.
- rdata  out  32  load result; held until the next load completes.
- dm_addr  out  ADDR_W  data-memory word address.
- dm_din  out  32  data-memory write data.
- dm_store  out  1  data-memory write enable.
- dm_load  out  1  data-memory read enable.
- dm_dout  in  32  data-memory read data, combinational.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low: when rst_n is low at a rising edge, state goes to IDLE, resp_valid=0, resp_err=0, rdata=RESET_RDATA, and all latched request fields are cleared.
- Memory strobes during reset: dm_store and dm_load are gated by rst_n combinationally, so no memory write occurs at a reset edge, including a reset that lands in WRITE (the in-flight store is aborted).
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- req_ready = (state==IDLE) and rst_n. A request is accepted on an edge where req_valid and req_ready are both high; addr, size, signed, we and wdata are latched then.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0; size=11. Such a request goes IDLE->RESP with resp_err=1, issues no dm_load/dm_store, and leaves rdata unchanged.
- Word index: dm_addr = latched addr[ADDR_W+1:2]. Upper address bits are ignored (wraps modulo 4 KiB). Little-endian lanes: byte k = bits[8k+7:8k], k = addr[1:0]; half h = bits[16h+15:16h], h = addr[1].
- Word store: IDLE->WRITE->RESP. WRITE drives dm_store=1 and dm_din=wdata. Latency accept-to-resp_valid: 2 cycles.
- Load: IDLE->LOAD->RESP. LOAD drives dm_load=1; at the end of LOAD, rdata gets the selected lane, zero-extended, or sign-extended if signed. Word loads pass through. Latency 2.
- Sub-word store: IDLE->RMW_RD->WRITE->RESP.
  - RMW_RD drives dm_load=1 and captures dm_dout into a merge register.
  - WRITE drives dm_store=1 with dm_din = merge register with only the target lane replaced by wdata[7:0] or wdata[15:0].
  - Latency 3.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- req_valid arriving in RESP is not accepted until the following IDLE cycle, so there is no back-to-back acceptance.
- Outside the states listed above, dm_load=0 and dm_store=0. dm_addr and dm_din hold their latched values.
- req_wdata/req_addr changes after acceptance have no effect.

Test Plan:
- Reset, then word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> dm_store high one cycle with dm_addr=4; load resp_valid 2 cycles after accept, rdata=0xDEADBEEF, resp_err=0.
- Word 0x11223344 at addr 0x20; store byte 0xAA to 0x22 -> dm_load cycle then dm_store cycle with dm_din=0x11AA3344; resp_valid 3 cycles after accept.
- Memory word 0x8000F07F at addr 0x30:
  - signed byte load 0x30 -> 0x0000007F.
  - signed byte load 0x31 -> 0xFFFFFFF0.
  - unsigned half load 0x32 -> 0x00008000.
  - signed half load 0x32 -> 0xFFFF8000.
- Misaligned and illegal requests:
  - Half load 0x41 -> resp_err=1 one cycle after accept, no dm_load, rdata unchanged.
  - Word store 0x42 -> resp_err=1, no dm_store.
  - size=11 -> resp_err=1.
- Half store 0xBEEF to 0x52 over 0x00000000, with rst_n low during WRITE -> no dm_store; after reset, word load 0x50 returns 0x00000000; req_ready=1, resp_valid=0 after reset.
- Address wrap: word store addr 0x1004 data 5, word load 0x0004 -> rdata=5.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Converts byte/half/word load-store requests into cycles on a
//            word-only data memory; sub-word stores use read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_store,
  output logic              dm_load,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] c_SIZE_B = 2'b00;
  localparam logic [1:0] c_SIZE_H = 2'b01;
  localparam logic [1:0] c_SIZE_W = 2'b10;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_we;
  logic              r_err;
  logic              w_accept;
  logic              w_misalign;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_val;
  logic [31:0]       w_merged;
  logic              w_unused_addr;

  // Address bits above the 4 KiB window are intentionally discarded.
  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  assign req_ready  = (r_state == S_IDLE) && rst_n;
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = (r_state == S_RESP) && r_err;
  assign rdata      = r_rdata;
  assign dm_addr    = r_addr[ADDR_W+1:2];
  assign dm_din     = w_merged;
  assign dm_load    = rst_n && ((r_state == S_LOAD) || (r_state == S_RMW_RD));
  assign dm_store   = rst_n && (r_state == S_WRITE) && r_we;

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      c_SIZE_B: w_misalign = 1'b0;
      c_SIZE_H: w_misalign = req_addr[0];
      c_SIZE_W: w_misalign = |req_addr[1:0];
      default:  w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign)                 w_next = S_RESP;
          else if (!req_we)               w_next = S_LOAD;
          else if (req_size == c_SIZE_W)  w_next = S_WRITE;
          else                            w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Little-endian lane extraction for loads.
  always_comb begin
    w_byte     = dm_dout[{r_addr[1:0], 3'b000} +: 8];
    w_half     = dm_dout[{r_addr[1], 4'b0000} +: 16];
    w_load_val = dm_dout;
    case (r_size)
      c_SIZE_B: w_load_val = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      c_SIZE_H: w_load_val = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default:  w_load_val = dm_dout;
    endcase
  end

  // Sub-word stores replace only the target lane of the word read back in RMW_RD.
  always_comb begin
    w_merged = r_merge;
    case (r_size)
      c_SIZE_B: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      c_SIZE_H: w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default:  w_merged = r_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= RESET_RDATA;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= req_addr[ADDR_W+1:0];
        r_wdata  <= req_wdata;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_we     <= req_we;
        r_err    <= w_misalign;
      end
      if (r_state == S_LOAD)   r_rdata <= w_load_val;
      if (r_state == S_RMW_RD) r_merge <= dm_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a
//            behavioural word memory attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_store;
  logic              dm_load;
  logic [31:0]       dm_dout;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat, n_ld, n_st;
  logic [31:0] st_din;
  logic [31:0] st_addr;
  logic        got_err;

  mem_access_unit #(.ADDR_W(ADDR_W), .RESET_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_store(dm_store), .dm_load(dm_load), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dm_store) mem[dm_addr] <= dm_din;
  assign dm_dout = dm_load ? mem[dm_addr] : 32'h0BAD_F00D;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request, then scrambles the request inputs and tracks strobes until resp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
    req_size = 2'b10; req_we = ~we; req_signed = ~sg;
    lat = 1; n_ld = 0; n_st = 0; st_din = 32'h0; st_addr = 32'h0;
    forever begin
      if (dm_load) n_ld++;
      if (dm_store) begin
        n_st++;
        st_din  = dm_din;
        st_addr = {22'h0, dm_addr};
      end
      if (resp_valid || lat >= 8) break;
      @(posedge clk); #1;
      lat++;
    end
    got_err = resp_err;
    check("resp_seen", resp_valid, 1'b1);
    check("ready_in_resp", req_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_store", dm_store, 1'b0);
    check("rst_load", dm_load, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 1'b1);

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("ws_lat", lat, 2);
    check("ws_nst", n_st, 1);
    check("ws_nld", n_ld, 0);
    check("ws_addr", st_addr, 4);
    check("ws_din", st_din, 32'hDEAD_BEEF);
    check("ws_err", got_err, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("wl_lat", lat, 2);
    check("wl_nld", n_ld, 1);
    check("wl_rdata", rdata, 32'hDEAD_BEEF);
    check("wl_err", got_err, 1'b0);

    // Byte read-modify-write
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA);
    check("bs_lat", lat, 3);
    check("bs_nld", n_ld, 1);
    check("bs_nst", n_st, 1);
    check("bs_addr", st_addr, 8);
    check("bs_din", st_din, 32'h11AA_3344);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("bs_readback", rdata, 32'h11AA_3344);

    // Sub-word loads and extension
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h8000_F07F);
    do_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0);
    check("lb_30", rdata, 32'h0000_007F);
    check("lb_lat", lat, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h31, 32'h0);
    check("lb_31", rdata, 32'hFFFF_FFF0);
    do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    check("lhu_32", rdata, 32'h0000_8000);
    do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    check("lh_32", rdata, 32'hFFFF_8000);
    do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0);
    check("lbu_33", rdata, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);
    check("lhu_30", rdata, 32'h0000_F07F);

    // Misaligned and illegal requests
    do_req(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
    check("mis_h_lat", lat, 1);
    check("mis_h_err", got_err, 1'b1);
    check("mis_h_nld", n_ld, 0);
    check("mis_h_rdata", rdata, 32'h0000_F07F);
    do_req(1'b1, 2'b10, 1'b0, 32'h42, 32'h1234_5678);
    check("mis_w_err", got_err, 1'b1);
    check("mis_w_nst", n_st, 0);
    check("mis_w_lat", lat, 1);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    check("ill_err", got_err, 1'b1);
    check("ill_nld", n_ld, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("after_err_clean", got_err, 1'b0);
    check("after_err_rdata", rdata, 32'h8000_F07F);

    // Reset landing in WRITE aborts the store
    do_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h0000_0000);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h52; req_wdata = 32'h0000_BEEF;
    while (!req_ready) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_rd_load", dm_load, 1'b1);
    @(posedge clk); #1;
    check("write_store", dm_store, 1'b1);
    check("write_din", dm_din, 32'hBEEF_0000);
    rst_n = 1'b0;
    #1;
    check("store_gated", dm_store, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort_ready", req_ready, 1'b1);
    check("abort_resp_valid", resp_valid, 1'b0);
    check("abort_rdata", rdata, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    check("abort_mem", rdata, 32'h0000_0000);

    // Upper address bits wrap
    do_req(1'b1, 2'b10, 1'b0, 32'h1004, 32'h0000_0005);
    check("wrap_addr", st_addr, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0004, 32'h0);
    check("wrap_rdata", rdata, 32'h0000_0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
